mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Execute-stage sibling of the ALU. Takes the same A/B register operands and performs MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Owns the architectural HI/LO registers and also services MTHI and MTLO.
- Raises busy so the pipeline control can stall any MFHI/MFLO or further mult/div issue until the result is written.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  single-cycle request strobe, qualified by op.
- op  input  3  operation code of type md_op_t.
- A  input  WIDTH  rs operand: multiplicand / dividend / MTHI-MTLO data.
- B  input  WIDTH  rt operand: multiplier / divisor.
- busy  output  1  high while an operation is in flight.
- hi  output  WIDTH  architectural HI register, registered.
- lo  output  WIDTH  architectural LO register, registered.

Behaviour:
- Clock and reset are fixed: one clock (clk); reset is asynchronous and active-high. Reset forces state=IDLE, busy=0, hi=0, lo=0 and discards all internal working registers, including mid-operation.
- op encoding: 000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved (treated as NONE).
- State machine: IDLE, CALC, FIX.
- IDLE accepts a request when start=1:
  - MTHI/MTLO: hi (or lo) <= A at that edge; stays in IDLE; busy stays 0.
  - MULT/MULTU/DIV/DIVU: latches operands and signs, clears the counter, goes to CALC; busy=1 from the next cycle.
  - NONE/reserved: ignored.
- CALC: one iteration per cycle for exactly WIDTH cycles (counter 0..WIDTH-1), then moves to FIX.
- FIX: applies the sign correction, writes hi/lo at the closing edge, returns to IDLE. busy falls at that same edge.
- Total busy = WIDTH+1 cycles (33 by default). hi/lo hold their old values for the whole of busy; they never show partial results.
- start while busy=1: ignored entirely, including MTHI/MTLO. Control must stall; the unit does not queue.
- Multiply:
  - Unsigned shift-add over magnitudes into a 2*WIDTH product; hi = upper half, lo = lower half.
  - MULT uses |A| and |B|, then negates the 2*WIDTH product in FIX if sign(A) xor sign(B).
  - MULTU never negates.
- Divide:
  - Restoring shift-subtract over magnitudes; lo = quotient, hi = remainder.
  - DIV negates the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Divide by zero (B=0, signed or unsigned): lo=all ones, hi=A unchanged; no sign correction; same latency.
  - Signed overflow (A=0x80000000, B=0xFFFFFFFF): lo=0x80000000, hi=0; no trap.
- Magnitude of the most negative value is taken as an unsigned WIDTH-bit number (0x80000000); the datapath needs no extra bit.
- No exceptions and no flush input. The pipeline does not issue mult/div on a squashed instruction.

Decomposition:
- Shared package mips_pkg holds:
  - md_op_t enum (3-bit) with the encodings above;
  - md_state_t enum {IDLE, CALC, FIX}.
- Sub-module md_iter_core holds the pure datapath: the 2*WIDTH accumulator/remainder register, the per-cycle add-or-subtract step, and the final conditional negation.
- mult_div_unit keeps the FSM, counter, operand/sign latches and HI/LO.

Test Plan:
- MULTU A=FFFFFFFF, B=FFFFFFFF -> busy high exactly 33 cycles; then hi=FFFFFFFE, lo=00000001; hi/lo unchanged during busy.
- MULT A=FFFFFFFE (-2), B=00000003 -> hi=FFFFFFFF, lo=FFFFFFFA. MULT A=80000000, B=80000000 -> hi=40000000, lo=00000000.
- DIV A=FFFFFFF9 (-7), B=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF. DIVU A=00000064, B=00000007 -> lo=0000000E, hi=00000002.
- DIVU A=12345678, B=0 -> lo=FFFFFFFF, hi=12345678. DIV A=80000000, B=FFFFFFFF -> lo=80000000, hi=00000000.
- MTHI A=DEADBEEF in IDLE -> hi=DEADBEEF next cycle, busy stays 0. During a busy MULT, start MTLO A=11111111 and start DIVU -> both ignored; lo ends with the MULT result.
- Start MULTU, assert reset at CALC cycle 10 -> busy=0, hi=lo=0 immediately (asynchronously). After release, a new DIVU 100/7 completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared encodings for the multiply/divide unit
package mips_pkg;

    typedef enum logic [2:0] {
        OP_NONE  = 3'b000,
        OP_MULT  = 3'b001,
        OP_MULTU = 3'b010,
        OP_DIV   = 3'b011,
        OP_DIVU  = 3'b100,
        OP_MTHI  = 3'b101,
        OP_MTLO  = 3'b110,
        OP_RSVD  = 3'b111
    } md_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

endpackage

// File: rtl/md_iter_core.sv
// md_iter_core: one-bit-per-cycle shift-add / restoring shift-subtract datapath with final sign fix
module md_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] init_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             neg_i,
    input  logic             rem_neg_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    logic [2*WIDTH-1:0] acc_q, acc_d, mul_next, div_next, prod;
    logic [WIDTH:0]     sum, rem_sh, diff;
    logic [WIDTH-1:0]   quot, rem;
    logic               ge;

    // Upper half holds the running sum / partial remainder, lower half the multiplier / dividend bits
    always_comb begin
        sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_i};
        mul_next = {acc_q[0] ? sum : {1'b0, acc_q[2*WIDTH-1:WIDTH]}, acc_q[WIDTH-1:1]};
        rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
        diff     = rem_sh - {1'b0, opnd_i};
        ge       = ~diff[WIDTH];
        div_next = {ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
        acc_d    = load_i ? {{WIDTH{1'b0}}, init_i} : step_i ? (is_div_i ? div_next : mul_next) : acc_q;
    end

    // Accumulator register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    // Product negates as a whole; quotient and remainder take their own signs
    always_comb begin
        prod = neg_i ? -acc_q : acc_q;
        quot = acc_q[WIDTH-1:0];
        rem  = acc_q[2*WIDTH-1:WIDTH];
        hi_o = is_div_i ? (rem_neg_i ? -rem : rem) : prod[2*WIDTH-1:WIDTH];
        lo_o = is_div_i ? (neg_i ? -quot : quot) : prod[WIDTH-1:0];
    end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and MTHI/MTLO
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_t           op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_t        state_q;
    logic [CW-1:0]    cnt_q;
    logic             busy_q, is_div_q, neg_q, rem_neg_q, dz_q;
    logic [WIDTH-1:0] opnd_q, a_q, hi_q, lo_q, core_hi, core_lo;
    logic             signed_op, div_op, md_op, a_neg, b_neg, accept;
    logic [WIDTH-1:0] a_mag, b_mag;

    // Decode the request and form operand magnitudes; 0x80000000 stays representable unsigned
    always_comb begin
        signed_op = op == OP_MULT || op == OP_DIV;
        div_op    = op == OP_DIV || op == OP_DIVU;
        md_op     = op == OP_MULT || op == OP_MULTU || div_op;
        a_neg     = signed_op & A[WIDTH-1];
        b_neg     = signed_op & B[WIDTH-1];
        a_mag     = a_neg ? -A : A;
        b_mag     = b_neg ? -B : B;
        accept    = state_q == IDLE && start && md_op;
    end

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk       (clk),
        .reset     (reset),
        .load_i    (accept),
        .step_i    (state_q == CALC),
        .is_div_i  (is_div_q),
        .init_i    (div_op ? a_mag : b_mag),
        .opnd_i    (opnd_q),
        .neg_i     (neg_q),
        .rem_neg_i (rem_neg_q),
        .hi_o      (core_hi),
        .lo_o      (core_lo)
    );

    // Control FSM: accept in IDLE, WIDTH iterations in CALC, commit HI/LO in FIX
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            dz_q      <= 1'b0;
            opnd_q    <= '0;
            a_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && op == OP_MTHI) hi_q <= A;
                    if (start && op == OP_MTLO) lo_q <= A;
                    if (accept) begin
                        state_q   <= CALC;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        is_div_q  <= div_op;
                        neg_q     <= a_neg ^ b_neg;
                        rem_neg_q <= div_op & a_neg;
                        dz_q      <= div_op && B == '0;
                        opnd_q    <= div_op ? b_mag : a_mag;
                        a_q       <= A;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= dz_q ? a_q : core_hi;
                    lo_q    <= dz_q ? '1 : core_lo;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed vectors against an arithmetic reference model of HI/LO/busy
module tb_mult_div_unit;
    import mips_pkg::*;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
    md_op_t      op = OP_NONE;
    logic [31:0] A = '0, B = '0;
    logic        busy;
    logic [31:0] hi, lo;

    int n_chk = 0, n_fail = 0;

    // Reference model state
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_pend;
    int          m_cnt;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model(md_op_t o, logic [31:0] a, logic [31:0] b);
        longint p;
        int sa, sb, q, r;
        sa = a;
        sb = b;
        case (o)
            OP_MULT: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            OP_MULTU: return {32'b0, a} * {32'b0, b};
            OP_DIV: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            OP_DIVU: begin
                if (b == 0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
            default: return 64'h0;
        endcase
    endfunction

    // Model: accepted mult/div busy for 33 cycles, then writes {hi,lo}
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_hi <= '0; m_lo <= '0; m_cnt <= 0; m_pend <= '0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_hi <= m_pend[63:32];
                m_lo <= m_pend[31:0];
            end
        end else if (start) begin
            if (op == OP_MTHI) m_hi <= A;
            if (op == OP_MTLO) m_lo <= A;
            if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) begin
                m_cnt  <= 33;
                m_pend <= model(op, A, B);
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        n_chk++;
        if (busy !== (m_cnt > 0) || hi !== m_hi || lo !== m_lo) begin
            n_fail++;
            $display("FAIL cycle t=%0t: busy=%b hi=%h lo=%h required busy=%b hi=%h lo=%h",
                     $time, busy, hi, lo, m_cnt > 0, m_hi, m_lo);
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic issue(md_op_t o, logic [31:0] a, logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (busy) check("busy_timeout", 64'(busy), 64'd0);
    endtask

    task automatic run(string name, md_op_t o, logic [31:0] a, logic [31:0] b,
                       logic [31:0] eh, logic [31:0] el);
        int n;
        check({name, "_model"}, model(o, a, b), {eh, el});
        issue(o, a, b);
        wait_idle(n);
        check({name, "_busy_len"}, 64'(n), 64'd33);
        check({name, "_hi"}, 64'(hi), 64'(eh));
        check({name, "_lo"}, 64'(lo), 64'(el));
    endtask

    initial begin
        int n;
        #12 check("reset_busy", 64'(busy), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;

        run("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run("mult_neg", OP_MULT, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run("div_neg", OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run("divu", OP_DIVU, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E);
        run("divu_zero", OP_DIVU, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF);
        run("div_zero", OP_DIV, 32'h87654321, 32'h00000000, 32'h87654321, 32'hFFFFFFFF);
        run("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run("div_rem_neg", OP_DIV, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);

        issue(OP_MTHI, 32'hDEADBEEF, 32'h0);
        check("mthi_hi", 64'(hi), 64'hDEADBEEF);
        check("mthi_busy", 64'(busy), 64'd0);
        issue(OP_MTLO, 32'hCAFEF00D, 32'h0);
        check("mtlo_lo", 64'(lo), 64'hCAFEF00D);
        issue(OP_RSVD, 32'h55555555, 32'h1);
        check("rsvd_ignored", {hi, lo}, 64'hDEADBEEF_CAFEF00D);

        issue(OP_MULTU, 32'h00010001, 32'h00000003);
        issue(OP_MTLO, 32'h11111111, 32'h0);
        issue(OP_DIVU, 32'h00000064, 32'h00000007);
        wait_idle(n);
        check("ignored_busy_len", 64'(n), 64'd29);
        check("ignored_hilo", {hi, lo}, 64'h00000000_00030003);

        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        #1 check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk) reset = 1'b0;
        run("after_reset", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
